// File: rtl/mdu_pkg.sv
// mdu_pkg: definitions shared by the M-extension issue controller, the
// decoder and the multiclock ALU.
//   - ALU_* alucodes for the multiclock operations
//   - mdu_state_e: issue controller FSM state encoding
//   - is_multiclock_op(): true for every alucode routed to the multiclock ALU
package mdu_pkg;

    localparam logic [5:0] ALU_MUL    = 6'd24;
    localparam logic [5:0] ALU_MULH   = 6'd25;
    localparam logic [5:0] ALU_MULHSU = 6'd26;
    localparam logic [5:0] ALU_MULHU  = 6'd27;
    localparam logic [5:0] ALU_DIV    = 6'd28;
    localparam logic [5:0] ALU_DIVU   = 6'd29;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_DRAIN  = 3'd4
    } mdu_state_e;

    function automatic logic is_multiclock_op(input logic [5:0] code);
        logic res;
        case (code)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU: res = 1'b1;
            default:           res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_cache.sv
// mdu_result_cache: one-entry memo of the last normally completed
// multiclock operation {alucode, op1, op2} -> result.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears the entry)
//   fill            capture fill_* as the new valid entry
//   inval           drop the entry (has priority over fill)
//   fill_*          operation and result to store
//   lookup_*        incoming request to compare against the entry
//   hit, hit_result combinational match and stored result
module mdu_result_cache
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fill,
    input  logic        inval,
    input  logic [5:0]  fill_alucode,
    input  logic [31:0] fill_op1,
    input  logic [31:0] fill_op2,
    input  logic [31:0] fill_result,
    input  logic [5:0]  lookup_alucode,
    input  logic [31:0] lookup_op1,
    input  logic [31:0] lookup_op2,
    output logic        hit,
    output logic [31:0] hit_result
);

    logic        valid_r;
    logic [5:0]  code_r;
    logic [31:0] op1_r;
    logic [31:0] op2_r;
    logic [31:0] result_r;

    // Entry storage: filled on a normal completion, dropped on reset/timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= 1'b0;
            code_r   <= 6'd0;
            op1_r    <= 32'd0;
            op2_r    <= 32'd0;
            result_r <= 32'd0;
        end else if (inval) begin
            valid_r  <= 1'b0;
        end else if (fill) begin
            valid_r  <= is_multiclock_op(fill_alucode);
            code_r   <= fill_alucode;
            op1_r    <= fill_op1;
            op2_r    <= fill_op2;
            result_r <= fill_result;
        end else begin
            valid_r  <= valid_r;
        end
    end

    // Full-key compare against the single entry.
    always_comb begin
        hit        = valid_r && (code_r == lookup_alucode) &&
                     (op1_r == lookup_op1) && (op2_r == lookup_op2);
        hit_result = result_r;
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/stall controller in front of the multiclock ALU.
// Accepts one M-extension op at a time, pulses alu_start, holds operands,
// stalls the pipeline until the ALU finishes and returns the tagged result.
// Handles flush by draining the (non-abortable) ALU and a stuck-ALU timeout.
// Optional build macro: MDU_RESULT_CACHE_EN adds a one-entry result cache
// so a repeated identical request answers without launching the ALU.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake from execute
//   req_alucode/op1/op2/rd   operation, operands, destination tag
//   flush                    pipeline flush
//   stall                    freeze upstream pipeline
//   alu_start                one-cycle launch pulse
//   alu_alucode/op1/op2      operands held stable to the ALU
//   alu_result, alu_done     ALU completion
//   resp_valid/result/rd     one-cycle tagged result strobe
//   timeout_err              sticky stuck-ALU flag
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MIN_LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_alucode,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic        alu_start,
    output logic [5:0]  alu_alucode,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result,
    input  logic        alu_done,
    output logic        resp_valid,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_rd,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TRUST = CNT_W'(MIN_LATENCY - 1);

    mdu_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [5:0]       alucode_r;
    logic [31:0]      op1_r;
    logic [31:0]      op2_r;
    logic [4:0]       rd_r;
    logic [31:0]      result_r;
    logic             timeout_err_r;

    logic             accept_s;
    logic             fill_s;
    logic             tmo_s;
    logic             done_ok_s;
    logic             expired_s;
    logic             hit_s;
    logic [31:0]      hit_result_s;

`ifdef MDU_RESULT_CACHE_EN
    mdu_result_cache u_cache (
        .clk            (clk),
        .rst            (rst),
        .fill           (fill_s),
        .inval          (tmo_s),
        .fill_alucode   (alucode_r),
        .fill_op1       (op1_r),
        .fill_op2       (op2_r),
        .fill_result    (alu_result),
        .lookup_alucode (req_alucode),
        .lookup_op1     (req_op1),
        .lookup_op2     (req_op2),
        .hit            (hit_s),
        .hit_result     (hit_result_s)
    );
`else
    assign hit_s        = 1'b0;
    assign hit_result_s = 32'd0;
`endif

    // Next-state and state-decoded control outputs.
    always_comb begin
        state_s    = state_r;
        req_ready  = 1'b0;
        stall      = 1'b0;
        alu_start  = 1'b0;
        resp_valid = 1'b0;
        accept_s   = 1'b0;
        fill_s     = 1'b0;
        tmo_s      = 1'b0;
        // A done seen too soon after launch may be the previous op's.
        done_ok_s  = alu_done && (cnt_r >= CNT_TRUST);
        expired_s  = !done_ok_s && (cnt_r >= CNT_LAST);
        case (state_r)
            ST_IDLE: begin
                req_ready = !flush;
                stall     = req_valid && !flush;
                if (req_valid && !flush) begin
                    accept_s = 1'b1;
                    state_s  = hit_s ? ST_RESP : ST_LAUNCH;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                // The pulse goes out even when flushed: DRAIN then waits for it.
                alu_start = 1'b1;
                stall     = 1'b1;
                state_s   = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (done_ok_s) begin
                    fill_s  = !flush;
                    state_s = flush ? ST_IDLE : ST_RESP;
                end else if (expired_s) begin
                    tmo_s   = 1'b1;
                    state_s = flush ? ST_IDLE : ST_RESP;
                end else begin
                    state_s = flush ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_RESP: begin
                resp_valid = !flush;
                state_s    = ST_IDLE;
            end
            ST_DRAIN: begin
                if (done_ok_s) begin
                    state_s = ST_IDLE;
                end else if (expired_s) begin
                    tmo_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, saturating wait counter, operand/result latches, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            alucode_r     <= 6'd0;
            op1_r         <= 32'd0;
            op2_r         <= 32'd0;
            rd_r          <= 5'd0;
            result_r      <= 32'd0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= state_s;

            if (state_r == ST_LAUNCH) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) &&
                         (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end

            if (accept_s) begin
                alucode_r <= req_alucode;
                op1_r     <= req_op1;
                op2_r     <= req_op2;
                rd_r      <= req_rd;
            end else begin
                alucode_r <= alucode_r;
            end

            if (accept_s && hit_s) begin
                result_r <= hit_result_s;
            end else if (fill_s) begin
                result_r <= alu_result;
            end else if (tmo_s) begin
                result_r <= 32'd0;
            end else begin
                result_r <= result_r;
            end

            if (tmo_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign alu_alucode = alucode_r;
    assign alu_op1     = op1_r;
    assign alu_op2     = op2_r;
    assign resp_result = result_r;
    assign resp_rd     = rd_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural multiclock ALU:
// pipelined multiplies complete 5 cycles after start, divides 12 cycles;
// done is sticky and drops one cycle after the next start (so a stale done
// overlaps the first cycle of every new op); "stuck" forces done low.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_alucode;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;
    logic        alu_start;
    logic [5:0]  alu_alucode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;
    logic        alu_done;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic [4:0]  resp_rd;
    logic        timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_resp  = 0;

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(64), .MIN_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alucode(req_alucode), .req_op1(req_op1), .req_op2(req_op2),
        .req_rd(req_rd), .flush(flush), .stall(stall),
        .alu_start(alu_start), .alu_alucode(alu_alucode),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_done(alu_done),
        .resp_valid(resp_valid), .resp_result(resp_result),
        .resp_rd(resp_rd), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    logic        stuck = 1'b0;
    logic [5:0]  m_code = 6'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic        m_start_d = 1'b0;
    logic [31:0] m_res = 32'd0;

    function automatic logic [31:0] alu_compute(input logic [5:0] c,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0]        up;
        logic signed [63:0] sp;
        logic signed [65:0] su;
        logic [31:0]        r;
        up = {32'd0, a} * {32'd0, b};
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        su = $signed({{34{a[31]}}, a}) * $signed({34'd0, b});
        case (c)
            ALU_MUL:    r = up[31:0];
            ALU_MULH:   r = sp[63:32];
            ALU_MULHSU: r = su[63:32];
            ALU_MULHU:  r = up[63:32];
            ALU_DIV: begin
                if (b == 32'd0) r = 32'hffffffff;
                else if (a == 32'h80000000 && b == 32'hffffffff) r = a;
                else r = $signed(a) / $signed(b);
            end
            ALU_DIVU:   r = (b == 32'd0) ? 32'hffffffff : a / b;
            default:    r = 32'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        m_start_d <= alu_start;
        if (alu_start) begin
            m_code <= alu_alucode;
            m_a    <= alu_op1;
            m_b    <= alu_op2;
            m_cnt  <= (alu_alucode == ALU_DIV || alu_alucode == ALU_DIVU) ? 12 : 5;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
        if (m_start_d) m_done <= 1'b0;
        if (!alu_start && m_cnt == 1) begin
            m_done <= 1'b1;
            m_res  <= alu_compute(m_code, m_a, m_b);
        end
    end

    assign alu_done   = m_done && !stuck;
    assign alu_result = m_res;

    always @(negedge clk) begin
        if (alu_start === 1'b1)  n_start <= n_start + 1;
        if (resp_valid === 1'b1) n_resp  <= n_resp + 1;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [5:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        req_alucode = c;
        req_op1     = a;
        req_op2     = b;
        req_rd      = rd;
        req_valid   = 1'b1;
    endtask

    task automatic wait_resp(input int maxc, output logic seen,
                             output logic stall_held, output int cyc);
        seen = 1'b0;
        stall_held = 1'b1;
        cyc = 0;
        while (!seen && cyc < maxc) begin
            step();
            cyc++;
            if (resp_valid) seen = 1'b1;
            else if (!stall && !flush) stall_held = 1'b0;
        end
    endtask

    logic seen, held, first_seen, got, early, saw_done;
    int   cyc, n_before;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_alucode = 6'd0; req_op1 = 32'd0;
        req_op2 = 32'd0; req_rd = 5'd0; flush = 1'b0;
        repeat (3) step();
        check1("rst_req_ready", req_ready, 1'b1);
        check1("rst_stall", stall, 1'b0);
        check1("rst_alu_start", alu_start, 1'b0);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check1("rst_timeout_err", timeout_err, 1'b0);
        check32("rst_resp_result", resp_result, 32'd0);
        check32("rst_alu_op1", alu_op1, 32'd0);
        rst = 1'b0;

        // flush together with req_valid in IDLE: no accept
        present(ALU_MUL, 32'd1, 32'd2, 5'd1);
        flush = 1'b1;
        #1;
        check1("flush_idle_ready", req_ready, 1'b0);
        check1("flush_idle_stall", stall, 1'b0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        check32("flush_idle_no_start", n_start, 32'd0);
        check1("flush_idle_ready_back", req_ready, 1'b1);

        // MUL 0x3141 * 0x5926 -> rd 5
        present(ALU_MUL, 32'h3141, 32'h5926, 5'd5);
        #1;
        check1("mul_accept_stall", stall, 1'b1);
        step();
        req_valid = 1'b0;
        #1;
        check1("mul_launch_start", alu_start, 1'b1);
        check32("mul_launch_op1", alu_op1, 32'h3141);
        wait_resp(50, seen, held, cyc);
        check1("mul_resp_seen", seen, 1'b1);
        check1("mul_stall_held", held, 1'b1);
        check32("mul_latency", cyc, 32'd7);
        check32("mul_result", resp_result, 32'h1126e8a6);
        check32("mul_rd", resp_rd, 32'd5);
        check1("mul_resp_stall", stall, 1'b0);
        step();
        check1("mul_resp_once", resp_valid, 1'b0);
        check32("mul_one_start", n_start, 32'd1);
        check32("mul_one_resp", n_resp, 32'd1);

        // DIV 10/0 then MULH -4*7 back-to-back
        present(ALU_DIV, 32'd10, 32'd0, 5'd3);
        step();
        present(ALU_MULH, 32'hfffffffc, 32'd7, 5'd7);
        first_seen = 1'b0; got = 1'b0; early = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            if (resp_valid && !first_seen) begin
                first_seen = 1'b1;
                check32("div0_result", resp_result, 32'hffffffff);
                check32("div0_rd", resp_rd, 32'd3);
            end
            if (req_ready) begin
                got = 1'b1;
                if (!first_seen) early = 1'b1;
            end
        end
        check1("b2b_first_seen", first_seen, 1'b1);
        check1("b2b_ready_got", got, 1'b1);
        check1("b2b_ready_not_early", early, 1'b0);
        step();
        req_valid = 1'b0;
        wait_resp(50, seen, held, cyc);
        check1("mulh_seen", seen, 1'b1);
        check32("mulh_result", resp_result, 32'hffffffff);
        check32("mulh_rd", resp_rd, 32'd7);
        step();

        // MULHU flushed 3 cycles after alu_start: drain, no response
        n_before = n_resp;
        present(ALU_MULHU, 32'd12345678, 32'hffffffff, 5'd8);
        step();
        req_valid = 1'b0;
        check1("flush_launch_start", alu_start, 1'b1);
        step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check1("drain_stall", stall, 1'b0);
        check1("drain_ready", req_ready, 1'b0);
        saw_done = 1'b0; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (alu_done) saw_done = 1'b1;
            if (req_ready) got = 1'b1;
            else step();
        end
        check1("drain_ready_back", got, 1'b1);
        check1("drain_after_done", saw_done, 1'b1);
        check32("drain_no_resp", n_resp, n_before);

        present(ALU_DIVU, 32'hffffffff, 32'd1234, 5'd10);
        step();
        req_valid = 1'b0;
        wait_resp(50, seen, held, cyc);
        check1("divu_seen", seen, 1'b1);
        check32("divu_result", resp_result, 32'h00351bcc);
        check32("divu_rd", resp_rd, 32'd10);
        step();

        // flush during RESP suppresses the strobe
        n_before = n_resp;
        present(ALU_MUL, 32'd6, 32'd7, 5'd4);
        step();
        req_valid = 1'b0;
        wait_resp(50, seen, held, cyc);
        flush = 1'b1;
        #1;
        check1("resp_flush_valid", resp_valid, 1'b0);
        step();
        flush = 1'b0;
        #1;
        check1("resp_flush_idle", req_ready, 1'b1);
        check32("resp_flush_no_resp", n_resp, n_before);

        // stuck ALU: timeout after 64 WAIT cycles
        stuck = 1'b1;
        present(ALU_MUL, 32'd3, 32'd3, 5'd9);
        step();
        req_valid = 1'b0;
        check1("tmo_err_before", timeout_err, 1'b0);
        wait_resp(100, seen, held, cyc);
        check1("tmo_seen", seen, 1'b1);
        check32("tmo_cycles", cyc, 32'd65);
        check32("tmo_result", resp_result, 32'd0);
        check32("tmo_rd", resp_rd, 32'd9);
        check1("tmo_err_set", timeout_err, 1'b1);
        step();
        stuck = 1'b0;
        present(ALU_MUL, 32'd2, 32'd3, 5'd2);
        step();
        req_valid = 1'b0;
        wait_resp(50, seen, held, cyc);
        check32("post_tmo_result", resp_result, 32'd6);
        check1("tmo_err_sticky", timeout_err, 1'b1);
        step();

        // reset in WAIT, then DIV -20/7 under a stale done
        present(ALU_MUL, 32'd100, 32'd200, 5'd6);
        step();
        req_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        #1;
        check1("midrst_err_clear", timeout_err, 1'b0);
        check1("midrst_ready", req_ready, 1'b1);
        check1("midrst_stale_done", alu_done, 1'b1);
        check1("midrst_no_resp", resp_valid, 1'b0);
        present(ALU_DIV, 32'hffffffec, 32'd7, 5'd12);
        step();
        req_valid = 1'b0;
        wait_resp(50, seen, held, cyc);
        check1("div_neg_seen", seen, 1'b1);
        check32("div_neg_result", resp_result, 32'hfffffffe);
        check32("div_neg_rd", resp_rd, 32'd12);
        step();

        // identical MUL twice
        present(ALU_MUL, 32'h27182818, 32'h45904523, 5'd13);
        step();
        req_valid = 1'b0;
        wait_resp(50, seen, held, cyc);
        check32("rep1_result", resp_result, 32'he09bf348);
        step();
        n_before = n_start;
        present(ALU_MUL, 32'h27182818, 32'h45904523, 5'd14);
        #1;
        check1("rep2_accept_stall", stall, 1'b1);
        step();
        req_valid = 1'b0;
        #1;
`ifdef MDU_RESULT_CACHE_EN
        check1("rep2_hit_valid", resp_valid, 1'b1);
        check1("rep2_hit_no_start", alu_start, 1'b0);
        check1("rep2_hit_stall", stall, 1'b0);
        check32("rep2_hit_result", resp_result, 32'he09bf348);
        check32("rep2_hit_rd", resp_rd, 32'd14);
        step();
        check32("rep2_hit_starts", n_start, n_before);
`else
        check1("rep2_start", alu_start, 1'b1);
        wait_resp(50, seen, held, cyc);
        check32("rep2_result", resp_result, 32'he09bf348);
        check32("rep2_rd", resp_rd, 32'd14);
        step();
        check32("rep2_starts", n_start, n_before + 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue/stall controller between the execute stage and `multiclockalu` (pipelined MUL/MULH/MULHSU/MULHU, multi-cycle DIV/DIVU).
- Accepts one M-extension op at a time via valid/ready, pulses the ALU start, and holds operands stable.
- Stalls the pipeline until `done`, then returns the result tagged with its destination register.
- Handles pipeline flush (drain-and-discard) and a stuck-ALU timeout.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in WAIT without `alu_done` before forced abort (≥ MIN_LATENCY+1)
- MIN_LATENCY, 2, cycles after `alu_start` before `alu_done` is trusted; masks a stale `done` from the previous op

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute stage presents multiclock op
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_alucode  in  6  ALU_MUL..ALU_DIVU code
- req_op1  in  32  operand 1
- req_op2  in  32  operand 2
- req_rd  in  5  destination register tag
- flush  in  1  pipeline flush (branch mispredict/trap)
- stall  out  1  freeze upstream pipeline
- alu_start  out  1  drives is_multiclock_input, one-cycle pulse
- alu_alucode  out  6  held opcode to ALU
- alu_op1  out  32  held operand 1
- alu_op2  out  32  held operand 2
- alu_result  in  32  ALU result
- alu_done  in  1  ALU done
- resp_valid  out  1  one-cycle result strobe
- resp_result  out  32  result
- resp_rd  out  5  tag of result
- timeout_err  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- States: IDLE, LAUNCH, WAIT, RESP, DRAIN. Reset → IDLE; all outputs 0, latched operands/tag 0, counter 0.
- IDLE:
  - req_ready=1. On accept (and !flush), latch alucode/op1/op2/rd → LAUNCH.
  - flush&&req_valid in the same cycle: no accept.
  - alu_done ignored.
- LAUNCH: alu_start=1 for exactly one cycle; counter cleared → WAIT.
- WAIT:
  - counter increments each cycle.
  - alu_done accepted only when counter ≥ MIN_LATENCY-1; latch alu_result → RESP.
  - Counter reaching TIMEOUT_CYCLES without done: set timeout_err, resp_result=0 → RESP.
- RESP: resp_valid=1 one cycle with latched result/rd → IDLE.
- Flush:
  - In LAUNCH or WAIT → DRAIN. The ALU cannot be aborted; DRAIN waits for a qualified alu_done or timeout, discards the result, and emits no resp_valid → IDLE.
  - In RESP: resp_valid suppressed that cycle → IDLE.
  - In DRAIN: no effect.
- stall = (IDLE&&req_valid&&!flush) | LAUNCH | WAIT. Deasserted in RESP and DRAIN.
- Latency: accept edge T; alu_start during T+1; done qualified at D; resp_valid during D+1. MUL on a 5-stage ALU gives ~8 cycles accept→resp.
- alu_alucode/op1/op2 hold latched values from LAUNCH through WAIT/DRAIN; they may change only in IDLE.
- Reset mid-op: immediate IDLE. The ALU keeps running (no reset) and its late done is ignored in IDLE; the MIN_LATENCY mask covers a subsequent launch.
- Counter is wide enough for TIMEOUT_CYCLES and saturates, never wraps.

Optional Feature:
- Macro MDU_RESULT_CACHE_EN.
- Defined:
  - One-entry cache {valid, alucode, op1, op2, result}, filled in WAIT→RESP on a normal done. Never filled from DRAIN or timeout.
  - A request matching all three fields goes IDLE→RESP directly: resp_valid the cycle after accept, no alu_start. stall is high only in the accept cycle.
  - Cache invalidated by rst and timeout; flush does not invalidate.
- Undefined: no cache; every request launches the ALU.

Decomposition:
- Shared package mdu_pkg: ALU_* alucode constants (MUL, MULH, MULHSU, MULHU, DIV, DIVU, shared with the ALU/decoder), state enum, is_multiclock_op() function.
- Sub-module mdu_result_cache (entry storage + compare), instantiated only under MDU_RESULT_CACHE_EN.
- Bench ALU model: the real multiclockalu.

Test Plan:
- MUL op1=0x3141 op2=0x5926 rd=5 → one alu_start; resp_valid once with resp_result=0x1126e8a6, resp_rd=5; stall high from accept until resp cycle.
- DIV op1=10 op2=0 rd=3, then MULH op1=-4 op2=7 back-to-back → 0xffffffff rd=3, then 0xffffffff; second req_ready only after first resp_valid.
- MULHU 12345678×0xffffffff with flush 3 cycles after alu_start → no resp_valid; req_ready returns after ALU done. Next DIVU 0xffffffff/1234 returns 0x00351bcc.
- Stub ALU holding alu_done=0 → after 64 WAIT cycles timeout_err=1, resp_valid with resp_result=0; timeout_err stays 1 until rst.
- rst asserted during WAIT of a MUL, then immediately DIV -20/7 → stale done ignored; resp_result=0xfffffffe.
- With MDU_RESULT_CACHE_EN: MUL 0x27182818×0x45904523 twice → second resp_result=0xe09bf348 one cycle after accept, no alu_start pulse.
